// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Smallest n with 2**n >= value; lets users derive ADDR_W from a word depth.
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((1 << n) < value) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read keeps the FIFO show-ahead without an extra cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock show-ahead FIFO with threshold flags, flush and sticky error flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_flush,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_dout,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_empty,
    output logic              o_almost_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ram_we;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);

    // A write into a full FIFO still fits when the same cycle frees a slot.
    assign w_rd_ok  = i_re & ~w_empty;
    assign w_wr_ok  = i_we & (~w_full | w_rd_ok);
    assign w_ram_we = w_wr_ok & ~i_flush & ~reset;

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_tail),
        .i_wdata (i_din),
        .i_raddr (r_head),
        .o_rdata (o_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            if (i_err_clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            if (w_rd_ok) begin
                r_head <= r_head + 1'b1;
            end
            if (w_wr_ok) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh error outranks a same-cycle clear.
            if (i_we & ~w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (i_re & w_empty) begin
                r_underflow <= 1'b1;
            end else if (i_err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_count        = r_count;
    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (r_count <= LP_AE);
    assign o_almost_full  = (r_count >= LP_AF);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed plus randomised scoreboard bench for param_sync_fifo at DEPTH=4.
module tb_param_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] i_din = '0;
    logic          i_we = 1'b0;
    logic          i_re = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_err_clr = 1'b0;
    logic [DW-1:0] o_dout;
    logic [AW:0]   o_count;
    logic          o_empty, o_full, o_almost_empty, o_almost_full;
    logic          o_overflow, o_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    param_sync_fifo #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_din          (i_din),
        .i_we           (i_we),
        .i_re           (i_re),
        .i_flush        (i_flush),
        .i_err_clr      (i_err_clr),
        .o_dout         (o_dout),
        .o_count        (o_count),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_almost_empty (o_almost_empty),
        .o_almost_full  (o_almost_full),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = sb.size();
        check("count", 32'(o_count), 32'(n));
        check("empty", 32'(o_empty), 32'(n == 0));
        check("full", 32'(o_full), 32'(n == DEPTH));
        check("almost_empty", 32'(o_almost_empty), 32'(n <= 1));
        check("almost_full", 32'(o_almost_full), 32'(n >= 3));
        check("overflow", 32'(o_overflow), 32'(m_ovf));
        check("underflow", 32'(o_underflow), 32'(m_unf));
        if (n > 0) check("head_dout", 32'(o_dout), 32'(sb[0]));
    endtask

    // Drive one cycle, update the reference model, clock, then compare.
    task automatic cycle(input logic we, input logic [DW-1:0] d, input logic re,
                         input logic fl, input logic ec, input logic rs);
        int n;
        logic rd_ok, wr_ok;
        logic [DW-1:0] exp_word;
        i_we = we; i_din = d; i_re = re; i_flush = fl; i_err_clr = ec; reset = rs;
        n = sb.size();
        if (rs) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (fl) begin
            sb.delete();
            if (ec) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
        end else begin
            rd_ok = re && (n > 0);
            wr_ok = we && ((n < DEPTH) || rd_ok);
            if (rd_ok) begin
                exp_word = sb.pop_front();
                check("pop_dout", 32'(o_dout), 32'(exp_word));
            end
            if (we && !wr_ok) m_ovf = 1'b1;
            else if (ec) m_ovf = 1'b0;
            if (re && (n == 0)) m_unf = 1'b1;
            else if (ec) m_unf = 1'b0;
            if (wr_ok) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle(0, 8'h00, 0, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0, 1);
        repeat (3) cycle(0, 8'h00, 0, 0, 0, 0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);

        // Fill to DEPTH and check threshold transitions.
        cycle(1, 8'h11, 0, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0, 0);
        check("ae_drop_at_2", 32'(o_almost_empty), 32'd0);
        cycle(1, 8'h33, 0, 0, 0, 0);
        check("af_at_3", 32'(o_almost_full), 32'd1);
        cycle(1, 8'h44, 0, 0, 0, 0);
        check("full_at_4", 32'(o_full), 32'd1);
        check("dout_head_11", 32'(o_dout), 32'h11);

        cycle(1, 8'h55, 0, 0, 0, 0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd4);
        cycle(1, 8'h66, 1, 0, 0, 0);
        check("rw_full_dout", 32'(o_dout), 32'h22);
        check("rw_full_count", 32'(o_count), 32'd4);
        cycle(0, 8'h00, 0, 0, 1, 0);
        check("ovf_clr", 32'(o_overflow), 32'd0);

        // Drain across the 3->0 pointer wrap, then read once more.
        repeat (4) cycle(0, 8'h00, 1, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0, 0);
        check("unf_set", 32'(o_underflow), 32'd1);
        check("unf_count", 32'(o_count), 32'd0);

        cycle(0, 8'h00, 0, 0, 1, 0);
        cycle(1, 8'hA5, 1, 0, 0, 0);
        check("rw_empty_unf", 32'(o_underflow), 32'd1);
        check("rw_empty_dout", 32'(o_dout), 32'hA5);
        check("rw_empty_count", 32'(o_count), 32'd1);

        // Error set wins over a same-cycle clear.
        cycle(0, 8'h00, 0, 0, 0, 0);
        cycle(1, 8'hB1, 0, 0, 0, 0);
        cycle(1, 8'hB2, 0, 0, 0, 0);
        cycle(1, 8'hB3, 0, 1, 0, 0);
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_keeps_unf", 32'(o_underflow), 32'd1);
        cycle(0, 8'h00, 1, 0, 1, 0);
        check("set_beats_clr", 32'(o_underflow), 32'd1);

        cycle(1, 8'hC1, 0, 0, 0, 0);
        cycle(1, 8'hC2, 0, 0, 0, 0);
        cycle(1, 8'hC3, 0, 0, 0, 1);
        check("midfill_rst_count", 32'(o_count), 32'd0);
        check("midfill_rst_unf", 32'(o_underflow), 32'd0);

        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock, show-ahead FIFO with configurable data width and depth. It is the general-purpose byte/word buffer between UART/keyboard front-ends and the display/processing datapath.
It adds the following over the earlier 8-bit FIFO:
- true simultaneous read+write
- correct full detection
- programmable almost-full/almost-empty thresholds
- synchronous flush
- sticky overflow/underflow error flags

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W words (>=1)
AF_LEVEL, 2**ADDR_W-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
din  in  DATA_W  write data
we  in  1  write request
re  in  1  read request (pop head)
flush  in  1  synchronous empty, keeps error flags
err_clr  in  1  clears sticky error flags
dout  out  DATA_W  current head word (show-ahead)
count  out  ADDR_W+1  words stored, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (clk edge with reset=1), highest priority:
  - head=0, tail=0, count=0, overflow=0, underflow=0
  - hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), i.e. 0 for legal values
  - memory contents not cleared
- Flags empty/full/almost_* are combinational decodes of the registered count; no extra latency.
- dout = mem[head], combinational from registered head. Value is don't-care when empty; the bench must not check it then.
- Read accept: rd_ok = re & ~empty. Write accept: wr_ok = we & (~full | rd_ok).
  - Write when full is accepted only if a read is accepted in the same cycle.
- On rd_ok: head <= head+1. On wr_ok: mem[tail] <= din, tail <= tail+1.
  - count <= count + wr_ok - rd_ok, so count is unchanged on a simultaneous accepted read+write.
- Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally. count is ADDR_W+1 bits so DEPTH is representable.
- Read when empty with we=1: read rejected (underflow sets), write accepted, count 0->1.
- Latency: a word written into an empty FIFO appears on dout and clears empty on the cycle after the write edge.
- Rejected read (re & empty): underflow <= 1. Rejected write (we & ~wr_ok): overflow <= 1. No pointer or count change in either case.
- err_clr=1 clears both sticky flags. If a new error occurs in the same cycle, set wins.
- flush=1 (reset=0):
  - head=tail=count=0
  - same-cycle re/we ignored and do not raise error flags
  - err_clr still honoured
- Priority: reset > flush > read/write. Reset or flush mid-stream discards all stored data immediately. No state machine beyond the pointer/count registers; all outputs are registered-state derived.

Decomposition:
- Shared package fifo_pkg:
  - default DATA_W/ADDR_W constants
  - function clog2 for users sizing ADDR_W from a depth
- Sub-module fifo_ram: simple dual-port RAM, DEPTH x DATA_W, one synchronous write port, one asynchronous read port. It keeps storage inferable as distributed RAM; the pointer/count/flag control lives in param_sync_fifo.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- DATA_W=8, ADDR_W=2 (DEPTH=4), AF_LEVEL=3, AE_LEVEL=1:
  - write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops at count=2; almost_full at count=3; full at 4; dout=0x11 throughout.
- Full FIFO:
  - we=1, din=0x55, re=0 -> rejected, overflow=1, count stays 4.
  - next cycle re=1, we=1, din=0x66 -> both accepted, count 4, dout=0x22.
  - err_clr -> overflow=0.
- Drain all 4 words:
  - expect 0x22,0x33,0x44,0x66 in order, with pointer wrap across address 3->0.
  - extra re -> underflow=1, count=0.
- Empty FIFO with re=1, we=1, din=0xA5 -> underflow=1, count=1 next cycle, dout=0xA5.
- Write 3 words, then pulse flush with we=1 -> count=0, empty=1, error flags unchanged.
  - Repeat with reset asserted mid-fill -> all outputs return to reset values in one cycle.
